// File: rtl/source_sequencer.sv
// source_sequencer: turns SPIKE/RUN/CLEAR/SYNC commands into network packets
//
// Optional feature macro: SRC_SEQ_STATS_EN (saturating emitted-packet counter on pkt_count).
//
// Ports:
//   clk, rst              single rising-edge clock, synchronous active-high reset
//   cmd_valid/cmd_ready   command handshake; commands are accepted only in IDLE
//   cmd_op                0 SPIKE, 1 RUN, 2 CLEAR, 3 SYNC
//   cmd_arg               RUN repeat count
//   cmd_chg               SPIKE charges, input 0 most significant
//   pkt_valid/pkt_ready   packet handshake towards the network source
//   pkt                   {SNC, CLR, charges}
//   busy                  high whenever a command is in progress
//   run_left              packets remaining in the current RUN, 0 otherwise
//   pkt_count             emitted-packet statistic (0 when stats are disabled)
module source_sequencer #(
    parameter int NUM_INP = 4,
    parameter int CHARGE_WIDTH = 8,
    parameter int RUN_WIDTH = 16,
    localparam int PKT_WIDTH = 2 + NUM_INP * CHARGE_WIDTH
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            cmd_valid,
    output logic                            cmd_ready,
    input  logic [1:0]                      cmd_op,
    input  logic [RUN_WIDTH-1:0]            cmd_arg,
    input  logic [NUM_INP*CHARGE_WIDTH-1:0] cmd_chg,
    output logic                            pkt_valid,
    input  logic                            pkt_ready,
    output logic [PKT_WIDTH-1:0]            pkt,
    output logic                            busy,
    output logic [RUN_WIDTH-1:0]            run_left,
    output logic [31:0]                     pkt_count
);
    typedef enum logic [1:0] {IDLE, EMIT, RUN} state_e;
    localparam logic [1:0] OP_SPIKE = 2'd0;
    localparam logic [1:0] OP_RUN   = 2'd1;
    localparam logic [1:0] OP_CLEAR = 2'd2;
    localparam logic [1:0] OP_SYNC  = 2'd3;
    state_e                 state_q, state_d;
    logic [PKT_WIDTH-1:0]   pkt_q, pkt_d;
    logic [RUN_WIDTH-1:0]   run_left_q, run_left_d;
    assign cmd_ready = state_q == IDLE;
    assign pkt_valid = state_q != IDLE;
    assign busy      = state_q != IDLE;
    assign pkt       = pkt_q;
    assign run_left  = run_left_q;
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            pkt_q      <= '0;
            run_left_q <= '0;
        end else begin
            state_q    <= state_d;
            pkt_q      <= pkt_d;
            run_left_q <= run_left_d;
        end
    end
    always_comb begin
        state_d    = state_q;
        pkt_d      = pkt_q;
        run_left_d = run_left_q;
        case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    if (cmd_op == OP_RUN) begin
                        // a zero-length RUN is consumed without leaving IDLE
                        if (cmd_arg != '0) begin
                            state_d    = RUN;
                            pkt_d      = '0;
                            run_left_d = cmd_arg;
                        end
                    end else begin
                        state_d = EMIT;
                        pkt_d   = {cmd_op == OP_SYNC, cmd_op == OP_CLEAR,
                                   cmd_op == OP_SPIKE ? cmd_chg : '0};
                    end
                end
            end
            EMIT: begin
                if (pkt_ready) state_d = IDLE;
            end
            RUN: begin
                if (pkt_ready) begin
                    run_left_d = run_left_q - RUN_WIDTH'(1);
                    if (run_left_q == RUN_WIDTH'(1)) state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end
`ifdef SRC_SEQ_STATS_EN
    logic [31:0] pkt_count_q;
    always_ff @(posedge clk) begin
        if (rst) pkt_count_q <= '0;
        else if (pkt_valid && pkt_ready && pkt_count_q != '1) pkt_count_q <= pkt_count_q + 32'd1;
    end
    assign pkt_count = pkt_count_q;
`else
    assign pkt_count = '0;
`endif
endmodule

// File: doc/source_sequencer.md
SOURCE_SEQUENCER -- requirements
Module: source_sequencer

Interface
REQ-001 SHALL have parameter NUM_INP, default 4, number of network input channels.
REQ-002 SHALL have parameter CHARGE_WIDTH, default 8, signed charge width per input.
REQ-003 SHALL have parameter RUN_WIDTH, default 16, width of the RUN repeat count.
REQ-004 SHALL define PKT_WIDTH = 2 + NUM_INP*CHARGE_WIDTH:
  - pkt[PKT_WIDTH-1] = SNC flag.
  - pkt[PKT_WIDTH-2] = CLR flag.
  - Charges follow, input 0 most significant.
REQ-005 SHALL have port clk  input  1  single clock; all logic is rising-edge.
REQ-006 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-007 SHALL have port cmd_valid  input  1  command present.
REQ-008 SHALL have port cmd_ready  output  1  command accepted this cycle when high with cmd_valid.
REQ-009 SHALL have port cmd_op  input  2  opcode: 0 SPIKE, 1 RUN, 2 CLEAR, 3 SYNC.
REQ-010 SHALL have port cmd_arg  input  RUN_WIDTH  RUN repeat count; ignored for other opcodes.
REQ-011 SHALL have port cmd_chg  input  NUM_INP*CHARGE_WIDTH  SPIKE charges, same packing as pkt.
REQ-012 SHALL have port pkt_valid  output  1  packet present to the network source.
REQ-013 SHALL have port pkt_ready  input  1  downstream (network) ready.
REQ-014 SHALL have port pkt  output  PKT_WIDTH  packet word.
REQ-015 SHALL have port busy  output  1  high whenever state is not IDLE.
REQ-016 SHALL have port run_left  output  RUN_WIDTH  packets remaining in the current RUN; 0 otherwise.
REQ-017 SHALL have port pkt_count  output  32  emitted-packet statistic (see Configuration).

Function
REQ-018 SHALL implement states IDLE, EMIT (single packet) and RUN (repeated packets).
REQ-019 cmd_ready SHALL equal (state == IDLE); commands are accepted only in IDLE.
REQ-020 On accept, the sequencer SHALL load the output packet register and enter its next state:
  - SPIKE -> pkt = {0,0,cmd_chg}, enter EMIT.
  - CLEAR -> pkt = {0,1,zeros}, enter EMIT.
  - SYNC -> pkt = {1,0,zeros}, enter EMIT.
  - RUN with cmd_arg>0 -> pkt = all zeros, run_left = cmd_arg, enter RUN.
REQ-021 RUN with cmd_arg == 0 SHALL be consumed with no packet emitted, and the state SHALL remain IDLE.
REQ-022 pkt_valid SHALL be high exactly in EMIT and RUN, first asserted the cycle after command accept (latency 1).
REQ-023 pkt and pkt_valid SHALL hold stable while pkt_valid && !pkt_ready; pkt_valid SHALL never drop before the handshake.
REQ-024 EMIT: on pkt_valid && pkt_ready the state SHALL go to IDLE.
REQ-025 RUN: each handshake SHALL decrement run_left; a handshake with run_left == 1 SHALL set run_left = 0 and go to IDLE.
REQ-026 A RUN of N SHALL emit exactly N zero packets, back-to-back when pkt_ready is held high.
REQ-027 cmd_ready SHALL rise the cycle after the final handshake; minimum command-to-command period is 2 cycles.
REQ-028 Command inputs SHALL be ignored outside IDLE, even if cmd_valid is high.

Reset
REQ-029 While rst is high at a clock edge, the block SHALL:
  - Set state = IDLE, pkt_valid = 0, pkt = 0, run_left = 0, busy = 0, pkt_count = 0.
  - Hold cmd_ready = 1 after that edge.
REQ-030 Reset mid-RUN or mid-EMIT SHALL abandon the command; no further packets from it are emitted.

Configuration
REQ-031 With macro SRC_SEQ_STATS_EN defined, pkt_count SHALL increment on every pkt handshake and saturate at 2^32-1.
REQ-032 With SRC_SEQ_STATS_EN undefined, pkt_count SHALL be constant 0 and no counter register SHALL be synthesized.

Verification
REQ-033 SPIKE, chg={8'h05,8'hFB,0,0}, pkt_ready=1 -> pkt_valid one cycle later with pkt=0x0005FB0000; IDLE the next cycle.
REQ-034 RUN, arg=3, pkt_ready=1 -> three consecutive zero packets; run_left reads 3,2,1 on them; cmd_ready returns after the 3rd.
REQ-035 CLEAR with pkt_ready=0 for 4 cycles, then 1 -> pkt=0x1_0000_0000 held stable all 5 cycles; exactly one handshake.
REQ-036 RUN, arg=0 -> no pkt_valid; busy stays 0; next SYNC accepted the following cycle, giving pkt MSB=1.
REQ-037 RUN, arg=10, rst asserted after the 4th handshake -> pkt_valid=0 and run_left=0 next cycle; no further packets.
REQ-038 With SRC_SEQ_STATS_EN: SPIKE + RUN 5 + SYNC -> pkt_count=7; without the macro -> pkt_count=0 throughout.
